uart_rx: RTL and testbench

- UART serial receiver; consumes the 16x oversampling `s_tick` from the team's baud-rate tick generator.
- Each bit period is 16 ticks. Start bit is validated at mid-bit; each data bit, optional parity and stop bit are sampled at mid-bit.
- Delivers the received word with a one-cycle done strobe plus frame and parity error flags to the host-side logic (FIFO or controller).

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver with frame and parity error flags
// Start bit is qualified at mid-bit; data, parity and stop bits are sampled mid-bit.
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);
    localparam logic [4:0] S_STOP  = 5'(SB_TICK - 1);
    localparam logic       ODD_BIT = (PARITY_ODD != 0);

    state_t          state_q, state_d;
    logic            sync1_q, rx_s_q;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            perr_q, perr_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            perr_o_q, perr_o_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            state_q  <= IDLE;
            s_q      <= '0;
            n_q      <= '0;
            b_q      <= '0;
            perr_q   <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_o_q <= 1'b0;
        end else begin
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            perr_q   <= perr_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            perr_o_q <= perr_o_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        perr_d   = perr_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        ferr_d   = ferr_q;
        perr_o_d = perr_o_q;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 5'd7) begin
                        // A line that is high again at mid start bit was only a glitch.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 5'd15) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == 5'd15) begin
                        perr_d  = (^b_q ^ rx_s_q) ^ ODD_BIT;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d  = IDLE;
                        dout_d   = b_q;
                        ferr_d   = ~rx_s_q;
                        perr_o_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_o_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
// Three receivers (no parity, even, odd) share one serial driver selected by sel.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_tick = 1'b0;
    logic rx_line = 1'b1;
    int   sel = 0;
    logic rx0, rx1, rx2;
    logic [7:0] dout0, dout1, dout2;
    logic done0, done1, done2, ferr0, ferr1, ferr2, perr0, perr1, perr2, busy0, busy1, busy2;

    int vectors = 0;
    int miscompares = 0;
    longint cyc = 0;
    longint last_done0 = 0;
    longint prev_done0 = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    assign rx0 = (sel == 0) ? rx_line : 1'b1;
    assign rx1 = (sel == 1) ? rx_line : 1'b1;
    assign rx2 = (sel == 2) ? rx_line : 1'b1;

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick), .dout(dout0),
        .rx_done_tick(done0), .frame_err(ferr0), .parity_err(perr0), .busy(busy0));
    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick), .dout(dout1),
        .rx_done_tick(done1), .frame_err(ferr1), .parity_err(perr1), .busy(busy1));
    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick), .dout(dout2),
        .rx_done_tick(done2), .frame_err(ferr2), .parity_err(perr2), .busy(busy2));

    always #5 clk = ~clk;

    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tcnt++;
            s_tick = (tcnt % 4 == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!reset && done0) begin
                if (q0.size() == 0) check_eq("d0_unexpected_done", 1, 0);
                else begin
                    e = q0.pop_front();
                    check_eq("d0_dout", dout0, e[7:0]);
                    check_eq("d0_frame_err", ferr0, e[8]);
                    check_eq("d0_parity_err", perr0, e[9]);
                    prev_done0 = last_done0;
                    last_done0 = cyc;
                end
            end
            if (!reset && done1) begin
                if (q1.size() == 0) check_eq("d1_unexpected_done", 1, 0);
                else begin
                    e = q1.pop_front();
                    check_eq("d1_dout", dout1, e[7:0]);
                    check_eq("d1_frame_err", ferr1, e[8]);
                    check_eq("d1_parity_err", perr1, e[9]);
                end
            end
            if (!reset && done2) begin
                if (q2.size() == 0) check_eq("d2_unexpected_done", 1, 0);
                else begin
                    e = q2.pop_front();
                    check_eq("d2_dout", dout2, e[7:0]);
                    check_eq("d2_frame_err", ferr2, e[8]);
                    check_eq("d2_parity_err", perr2, e[9]);
                end
            end
        end
    end

    task automatic bit_time(input logic v, input int n);
        rx_line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] d, input bit par, input logic pv, input logic stop);
        logic pe;
        sel = s;
        pe = (s == 0) ? 1'b0 : ((^d) ^ pv ^ (s == 2));
        if (s == 0) q0.push_back({pe, ~stop, d});
        else if (s == 1) q1.push_back({pe, ~stop, d});
        else q2.push_back({pe, ~stop, d});
        bit_time(1'b0, 64);
        for (int i = 0; i < 8; i++) bit_time(d[i], 64);
        if (par) bit_time(pv, 64);
        if (stop) bit_time(1'b1, 64);
        else begin
            bit_time(1'b0, 40);
            bit_time(1'b1, 24);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
        #1;
        check_eq("drain_pending", q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dout", dout0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_frame_err", ferr0, 0);
        check_eq("rst_parity_err", perr0, 0);
        check_eq("rst_busy", busy0, 0);
        reset = 1'b0;
        bit_time(1'b1, 100);

        fork
            send(0, 8'hA5, 0, 1'b0, 1'b1);
            begin
                repeat (20) @(posedge clk);
                #1;
                check_eq("busy_in_frame", busy0, 1);
            end
        join
        drain();
        bit_time(1'b1, 40);
        check_eq("busy_idle", busy0, 0);

        send(0, 8'h3C, 0, 1'b0, 1'b1);
        send(0, 8'hC3, 0, 1'b0, 1'b1);
        drain();
        check_eq("b2b_gap", 32'(last_done0 - prev_done0), 640);
        bit_time(1'b1, 64);

        bit_time(1'b0, 20);
        bit_time(1'b1, 100);
        check_eq("glitch_busy", busy0, 0);
        check_eq("glitch_dout", dout0, 8'hC3);

        send(0, 8'h55, 0, 1'b0, 1'b0);
        bit_time(1'b1, 64);
        send(0, 8'h01, 0, 1'b0, 1'b1);
        drain();
        bit_time(1'b1, 64);

        send(1, 8'h07, 1, 1'b1, 1'b1);
        bit_time(1'b1, 64);
        send(1, 8'h07, 1, 1'b0, 1'b1);
        bit_time(1'b1, 64);
        send(2, 8'h07, 1, 1'b0, 1'b1);
        drain();
        bit_time(1'b1, 64);

        sel = 0;
        bit_time(1'b0, 64);
        for (int i = 0; i < 4; i++) bit_time(1'b1, 64);
        bit_time(1'b1, 20);
        reset = 1'b1;
        #1;
        check_eq("midrst_dout", dout0, 0);
        check_eq("midrst_frame_err", ferr0, 0);
        check_eq("midrst_busy", busy0, 0);
        check_eq("midrst_done", done0, 0);
        check_eq("midrst_parity_err_d1", perr1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bit_time(1'b1, 320);
        send(0, 8'h81, 0, 1'b0, 1'b1);
        drain();
        bit_time(1'b1, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
